aer_receiver: RTL and testbench

//  Receiving end of the 4-phase AER link driven by spike_core (AER_ADDR/AER_REQ/AER_ACK).
//  - Synchronises the incoming REQ and captures the bundled address.
//  - Decodes each event, buffers it in a small FIFO and presents it downstream on a valid/ready port.
//  - Acknowledges the sender; holds ACK low (backpressure) while the FIFO is full or the block is disabled.

---
 rtl/aer_pkg.sv | 29 ++
 rtl/aer_rx_fifo.sv | 54 +++++
 rtl/aer_receiver.sv | 130 +++++++++++++
 tb/tb_aer_receiver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared types for the AER receive path: event encoding, buffered event record
// and receiver handshake states.
package aer_pkg;

  localparam int AER_M = 8;

  typedef enum logic [1:0] {
    AER_SPIKE = 2'b00,
    AER_TSTEP = 2'b01,
    AER_RSV0  = 2'b10,
    AER_RSV1  = 2'b11
  } aer_evt_type_e;

  typedef struct packed {
    aer_evt_type_e          evt_type;
    logic [AER_M-1:0]       addr;
  } aer_evt_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_state_e;

  // Both reserved codes share the upper bit.
  function automatic logic is_reserved(input aer_evt_type_e t);
    return t[1];
  endfunction

endpackage

// File: rtl/aer_rx_fifo.sv
// First-word fall-through FIFO on a register array; head is always mem[rd_ptr].
// Full/empty come straight from the registered occupancy count.
module aer_rx_fifo
  import aer_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = aer_evt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/aer_receiver.sv
// AER 4-phase receiver: synchronises REQ, decodes the bundled address, buffers
// events in a FWFT FIFO and returns ACK, withholding it while full or disabled.
module aer_receiver
  import aer_pkg::*;
#(
  parameter int M     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             enable_i,
  input  logic [M+1:0]     AER_ADDR_i,
  input  logic             AER_REQ_i,
  output logic             AER_ACK_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [1:0]       evt_type_o,
  output logic [M-1:0]     evt_addr_o,
  output logic [CNT_W-1:0] evt_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             busy_o
);

  typedef struct packed {
    aer_evt_type_e evt_type;
    logic [M-1:0]  addr;
  } evt_t;

  logic       req_meta_q, req_s_q;
  rx_state_e  state_q, state_d;
  logic       ack_q, ack_d;
  logic       push, inc_evt, inc_drop;
  logic       fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0] evt_cnt_q, drop_cnt_q;
  aer_evt_type_e    in_type;
  evt_t             in_evt, head;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= AER_REQ_i;
      req_s_q    <= req_meta_q;
    end
  end

  assign in_type         = aer_evt_type_e'(AER_ADDR_i[M+1:M]);
  assign in_evt.evt_type = in_type;
  assign in_evt.addr     = (in_type == AER_TSTEP) ? '0 : AER_ADDR_i[M-1:0];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    push     = 1'b0;
    inc_evt  = 1'b0;
    inc_drop = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Full is checked before decode, so reserved events also wait for space.
        if (req_s_q && enable_i && !fifo_full) begin
          if (is_reserved(in_type)) begin
            inc_drop = 1'b1;
          end else begin
            push    = 1'b1;
            inc_evt = 1'b1;
          end
          state_d = S_ACK;
          ack_d   = 1'b1;
        end
      end
      S_ACK: begin
        if (!req_s_q) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (inc_evt && (evt_cnt_q != '1))   evt_cnt_q  <= evt_cnt_q + CNT_W'(1);
      if (inc_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign pop = evt_valid_o && evt_ready_i;

  aer_rx_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RSTN),
    .push_i      (push),
    .push_data_i (in_evt),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign AER_ACK_o    = ack_q;
  assign busy_o       = (state_q != S_IDLE);
  assign evt_valid_o  = !fifo_empty;
  assign evt_type_o   = fifo_empty ? 2'b00 : head.evt_type;
  assign evt_addr_o   = fifo_empty ? '0 : head.addr;
  assign evt_count_o  = evt_cnt_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_aer_receiver.sv
// Bench for aer_receiver: directed handshake scenarios plus randomized traffic,
// with a queue-based event model checked against the outputs every cycle.
module tb_aer_receiver;

  localparam int M     = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             enable_i;
  logic [M+1:0]     AER_ADDR_i;
  logic             AER_REQ_i;
  logic             AER_ACK_o;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [1:0]       evt_type_o;
  logic [M-1:0]     evt_addr_o;
  logic [CNT_W-1:0] evt_count_o;
  logic [CNT_W-1:0] drop_count_o;
  logic             busy_o;

  aer_receiver #(.M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .enable_i     (enable_i),
    .AER_ADDR_i   (AER_ADDR_i),
    .AER_REQ_i    (AER_REQ_i),
    .AER_ACK_o    (AER_ACK_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_type_o   (evt_type_o),
    .evt_addr_o   (evt_addr_o),
    .evt_count_o  (evt_count_o),
    .drop_count_o (drop_count_o),
    .busy_o       (busy_o)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Behavioural model: every accepted handshake (rising ACK) contributes one
  // decoded event or one drop; the consumer removes the head on valid&ready.
  logic [M+1:0] mq[$];
  int           m_evt, m_drop;
  logic         prev_ack, pop_next;

  initial begin
    m_evt = 0; m_drop = 0; prev_ack = 1'b0; pop_next = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        mq.delete();
        m_evt = 0; m_drop = 0; prev_ack = 1'b0; pop_next = 1'b0;
        check("rst_ack", AER_ACK_o, 0);
        check("rst_valid", evt_valid_o, 0);
        check("rst_evt_count", evt_count_o, 0);
        check("rst_drop_count", drop_count_o, 0);
      end else begin
        logic ack_rise;
        logic [1:0] t;
        ack_rise = AER_ACK_o && !prev_ack;
        if (ack_rise) check("accept_while_full", (mq.size() < DEPTH), 1);
        if (pop_next) void'(mq.pop_front());
        if (ack_rise) begin
          t = AER_ADDR_i[M+1:M];
          if (t[1]) m_drop++;
          else begin
            mq.push_back({t, (t == 2'b01) ? {M{1'b0}} : AER_ADDR_i[M-1:0]});
            m_evt++;
          end
        end
        prev_ack = AER_ACK_o;
        check("valid", evt_valid_o, (mq.size() > 0));
        if (mq.size() > 0) begin
          check("head_type", evt_type_o, mq[0][M+1:M]);
          check("head_addr", evt_addr_o, mq[0][M-1:0]);
        end
        check("evt_count", evt_count_o, m_evt);
        check("drop_count", drop_count_o, m_drop);
        check("busy_vs_ack", busy_o, AER_ACK_o);
        pop_next = (mq.size() > 0) && evt_ready_i;
      end
    end
  end

  logic rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (rand_ready) evt_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // One complete 4-phase handshake; exp_lat>0 pins both edge latencies.
  task automatic send(input logic [M+1:0] a, input int exp_lat, input string tag);
    int n_up, n_dn;
    n_up = 0; n_dn = 0;
    @(posedge CLK); #2;
    AER_ADDR_i = a;
    AER_REQ_i  = 1'b1;
    do begin @(posedge CLK); #1; n_up++; end while (!AER_ACK_o && n_up < 300);
    if (exp_lat > 0) check({tag, "_ack_lat"}, n_up, exp_lat);
    else             check({tag, "_acked"}, AER_ACK_o, 1);
    #1;
    AER_REQ_i = 1'b0;
    do begin @(posedge CLK); #1; n_dn++; end while (AER_ACK_o && n_dn < 300);
    if (exp_lat > 0) check({tag, "_fall_lat"}, n_dn, exp_lat);
    else             check({tag, "_released"}, AER_ACK_o, 0);
    $display("event %s addr=%03h ack_after=%0d release_after=%0d", tag, a, n_up, n_dn);
  endtask

  task automatic pop_one();
    @(posedge CLK); #2; evt_ready_i = 1'b1;
    @(posedge CLK); #2; evt_ready_i = 1'b0;
  endtask

  task automatic drain(input int cycles);
    @(posedge CLK); #2; evt_ready_i = 1'b1;
    repeat (cycles) @(posedge CLK);
    #2; evt_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    RSTN = 1'b0; enable_i = 1'b1; AER_REQ_i = 1'b0; AER_ADDR_i = '0; evt_ready_i = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_type", evt_type_o, 0);
    check("reset_addr", evt_addr_o, 0);
    check("reset_busy", busy_o, 0);
    #1; RSTN = 1'b1;

    // Single spike
    send(10'h005, 3, "spike");
    @(negedge CLK);
    check("spike_valid", evt_valid_o, 1);
    check("spike_type", evt_type_o, 2'b00);
    check("spike_addr", evt_addr_o, 8'h05);
    check("spike_count", evt_count_o, 1);
    pop_one();
    @(negedge CLK);
    check("spike_popped", evt_valid_o, 0);

    // Time-step marker: address field discarded
    send(10'h1FF, 3, "tstep");
    @(negedge CLK);
    check("tstep_type", evt_type_o, 2'b01);
    check("tstep_addr", evt_addr_o, 8'h00);
    pop_one();
    @(negedge CLK);
    check("tstep_popped", evt_valid_o, 0);

    // Reserved type: acknowledged but dropped
    send(10'h2AA, 3, "rsv");
    @(negedge CLK);
    check("rsv_valid", evt_valid_o, 0);
    check("rsv_drop", drop_count_o, 1);
    check("rsv_evt_count", evt_count_o, 2);

    // Backpressure: fill all 16 slots, 17th must wait for a pop
    for (int i = 0; i < DEPTH; i++) send({2'b00, 8'(i)}, 3, "fill");
    @(posedge CLK); #2;
    AER_ADDR_i = {2'b00, 8'd16};
    AER_REQ_i  = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("bp_hold_ack", AER_ACK_o, 0);
    check("bp_head_addr", evt_addr_o, 8'h00);
    #1; evt_ready_i = 1'b1;
    @(posedge CLK); #2; evt_ready_i = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!AER_ACK_o && n < 50);
    check("bp_ack_after_pop", n, 1);
    #1; AER_REQ_i = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (AER_ACK_o && n < 50);
    check("bp_release", AER_ACK_o, 0);
    $display("event bp17 addr=010 ack_after_pop=1 release_after=%0d", n);
    drain(24);
    @(negedge CLK);
    check("bp_drained", evt_valid_o, 0);
    check("bp_evt_count", evt_count_o, 19);

    // Disabled: REQ held high is ignored until enable returns
    @(posedge CLK); #2;
    enable_i = 1'b0; AER_ADDR_i = 10'h033; AER_REQ_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      check("dis_ack", AER_ACK_o, 0);
      check("dis_busy", busy_o, 0);
    end
    #1; enable_i = 1'b1;
    @(posedge CLK); #1;
    check("en_ack_1edge", AER_ACK_o, 1);
    #1; AER_REQ_i = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (AER_ACK_o && n < 50);
    check("en_release", AER_ACK_o, 0);
    $display("event enable addr=033 ack_after=1 release_after=%0d", n);
    drain(4);

    // Randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      send(10'($urandom), 0, "rand");
    end
    rand_ready = 1'b0;
    drain(30);
    @(negedge CLK);
    check("rand_drained", evt_valid_o, 0);

    // Reset while in S_ACK
    @(posedge CLK); #2;
    AER_ADDR_i = 10'h007; AER_REQ_i = 1'b1;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!AER_ACK_o && n < 50);
    check("rstmid_acked", AER_ACK_o, 1);
    #2; RSTN = 1'b0;
    #1;
    check("rstmid_ack_async", AER_ACK_o, 0);
    check("rstmid_valid_async", evt_valid_o, 0);
    check("rstmid_evt_count", evt_count_o, 0);
    check("rstmid_drop_count", drop_count_o, 0);
    AER_REQ_i = 1'b0;
    @(posedge CLK); #2; RSTN = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("post_rst_ack", AER_ACK_o, 0);
    check("post_rst_valid", evt_valid_o, 0);
    check("post_rst_count", evt_count_o, 0);
    $display("event reset_in_ack addr=007 no_event_after_release");

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
